aes_round_core: RTL and testbench
=================================

// Module: aes_round_core
// PURPOSE
//  Iterative AES encryption round engine: owns the 128-bit state register, drives the external
//  SubBytes array, consumes its output, applies ShiftRows, MixColumns, AddRoundKey, writes back.
//  One round per clock. Round keys come from an external key-schedule store via rk_idx/rk_in.
//  Sits between the block input interface and the ciphertext output interface.
// PARAMETERS
//  NR  10  number of rounds (10/12/14 for AES-128/192/256); rk_idx range 0..NR
// PORTS
//  clk          in   1    clock; all state updates on rising edge
//  rst          in   1    synchronous, active-high reset
//  in_valid     in   1    plaintext block valid
//  in_ready     out  1    core can accept a block
//  in_data      in   128  plaintext; [127:120] = byte 0 (s[0][0]), column-major per FIPS-197
//  rk_idx       out  4    round-key index requested this cycle
//  rk_in        in   128  round key for rk_idx, same cycle (combinational read), same byte order
//  sb_data_out  out  128  current state register, to SubBytes data_in
//  sb_data_in   in   128  SubBytes data_out (byte-wise S-box of sb_data_out)
//  out_valid    out  1    ciphertext valid
//  out_ready    in   1    downstream accepts ciphertext
//  out_data     out  128  ciphertext (= state register), same byte order
// BEHAVIOUR
//  Reset (rst=1 at edge): FSM=IDLE, round=0, state=0; outputs in_ready=1, out_valid=0,
//   rk_idx=0, sb_data_out=0, out_data=0. Reset overrides everything, including a block mid-round
//   (that block is discarded, no output produced).
//  FSM states and outputs:
//   IDLE:  in_ready=1, rk_idx=0. On in_valid: state<=in_data^rk_in, round<=1, ->ROUND.
//   ROUND: in_ready=0, rk_idx=round. Every cycle: state<=ARK(MC(SR(sb_data_in)),rk_in);
//          when round==NR MC is bypassed: state<=ARK(SR(sb_data_in),rk_in), ->DONE.
//          Otherwise round<=round+1. No stall inside ROUND.
//   DONE:  out_valid=1, in_ready=0, out_data=state held stable. On out_ready: ->IDLE, round<=0.
//  Latency: block accepted at edge N -> out_valid=1 after edge N+NR. Min spacing between
//   accepted blocks NR+2 cycles (accept, NR rounds, output handshake; new accept next IDLE cycle).
//  in_ready is 0 outside IDLE; in_valid/in_data ignored then. out_valid falls after the
//   out_ready edge. out_ready while not DONE is ignored.
//  ShiftRows: row r (bytes r,r+4,r+8,r+12) rotated left by r columns; s'[r][c]=s[r][(c+r)mod4].
//  MixColumns: per column, GF(2^8) mod x^8+x^4+x^3+x+1; xtime(b)=(b<<1)^(b[7]?8'h1b:0);
//   s0'=2s0^3s1^s2^s3, s1'=s0^2s1^3s2^s3, s2'=s0^s1^2s2^3s3, s3'=3s0^s1^s2^2s3.
//  AddRoundKey: bitwise XOR of full 128 bits.
//  sb_data_out always equals the state register (S-box path is combinational external,
//   loop closes through this block's state register only).
//  round counter is 4 bits; never exceeds NR; no wrap.
// TESTING
//  T1 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
//  T2 Same vector intermediate: after accept sb_data_out=193de3bea0f4e22b9ac68d2ae9f84808,
//     after round 1 sb_data_out=a49c7ff2689f352b6b5bea43026a5049, rk_idx steps 0,1..10.
//  T3 FIPS-197 App.C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff
//     -> 69c4e0d86a7b0430d8cdb78070b4c55a.
//  T4 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/out_data stable,
//     in_ready=0 with in_valid=1 held; block accepted only after out_ready pulse.
//  T5 Back-to-back: in_valid=1 and out_ready=1 continuously with T1,T3 -> both ciphertexts,
//     accepts 12 cycles apart.
//  T6 Reset at round 5 -> next cycle in_ready=1, out_valid=0, rk_idx=0; T1 rerun gives T1 result.

Source files
------------

// File: rtl/aes_round_core.sv
// rtl/aes_round_core.sv - iterative AES encryption round engine, one round per clock
module aes_round_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic [127:0] sb_data_out,
    input  logic [127:0] sb_data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] shifted;
    logic [127:0] mixed;

    // Byte k of a block sits at [127-8k -: 8]; byte k is s[k%4][k/4].
    function automatic logic [7:0] get_byte(input logic [127:0] w, input int k);
        return w[127 - 8*k -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r is rotated left by r columns: s'[r][c] = s[r][(c+r) mod 4].
    function automatic logic [127:0] shift_rows(input logic [127:0] w);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = get_byte(w, r + 4*(((c + r) % 4)));
            end
        end
        return o;
    endfunction

    // Column-wise multiply by the fixed MixColumns polynomial over GF(2^8).
    function automatic logic [127:0] mix_columns(input logic [127:0] w);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(w, 4*c);
            a1 = get_byte(w, 4*c + 1);
            a2 = get_byte(w, 4*c + 2);
            a3 = get_byte(w, 4*c + 3);
            o[127 - 8*(4*c)     -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            o[127 - 8*(4*c + 1) -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            o[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            o[127 - 8*(4*c + 3) -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round datapath: the S-box result comes back from outside, everything else is local.
    always_comb begin
        shifted = shift_rows(sb_data_in);
        mixed   = mix_columns(shifted);
    end

    // Next-state and handshake outputs; the last round skips MixColumns.
    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = round_q;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                rk_idx   = 4'd0;
                if (in_valid) begin
                    state_d = in_data ^ rk_in;
                    round_d = 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d = shifted ^ rk_in;
                    fsm_d   = ST_DONE;
                end else begin
                    state_d = mixed ^ rk_in;
                    round_d = round_q + 4'd1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State register; reset drops any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    assign sb_data_out = state_q;
    assign out_data    = state_q;

endmodule

// File: tb/tb_aes_round_core.sv
// tb/tb_aes_round_core.sv - self-checking bench for aes_round_core against an AES-128 model
module tb_aes_round_core;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_in;
    logic [127:0] sb_data_out;
    logic [127:0] sb_data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_checks;
    int n_pass;

    logic [127:0] rk_mem [2][11];
    int           key_sel;

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY3 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT3  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_core #(.NR(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .rk_idx      (rk_idx),
        .rk_in       (rk_in),
        .sb_data_out (sb_data_out),
        .sb_data_in  (sb_data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t, inv;
        t = x; inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t   = gmul(t, t);
            inv = gmul(inv, t);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] w);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = sbox(w[127 - 8*k -: 8]);
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [127:0] k, o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = pt[127 - 8*(r + 4*c) -: 8];
        k = round_key(key, 0);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ k[127 - 8*(r + 4*c) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[r][c] = sbox(st[r][(c + r) % 4]);
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    st[0][c] = gmul(8'h02, tmp[0][c]) ^ gmul(8'h03, tmp[1][c]) ^ tmp[2][c] ^ tmp[3][c];
                    st[1][c] = tmp[0][c] ^ gmul(8'h02, tmp[1][c]) ^ gmul(8'h03, tmp[2][c]) ^ tmp[3][c];
                    st[2][c] = tmp[0][c] ^ tmp[1][c] ^ gmul(8'h02, tmp[2][c]) ^ gmul(8'h03, tmp[3][c]);
                    st[3][c] = gmul(8'h03, tmp[0][c]) ^ tmp[1][c] ^ tmp[2][c] ^ gmul(8'h02, tmp[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
                end
            end
            k = round_key(key, rnd);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ k[127 - 8*(r + 4*c) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127 - 8*(r + 4*c) -: 8] = st[r][c];
        return o;
    endfunction

    // ---------------- environment: external S-box and key store ----------------
    always_comb sb_data_in = sub_block(sb_data_out);

    always_comb begin
        rk_in = '0;
        if (rk_idx <= 4'd10) rk_in = rk_mem[key_sel][rk_idx];
    end

    task automatic load_keys(input int slot, input logic [127:0] key);
        for (int i = 0; i < 11; i++) rk_mem[slot][i] = round_key(key, i);
    endtask

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One full block: accept, count latency, check result, then hand it off.
    task automatic run_block(input int slot, input logic [127:0] pt, input logic [127:0] exp,
                             input bit mid);
        int w;
        int lat;
        key_sel  = slot;
        in_data  = pt;
        in_valid = 1'b1;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check_eq("in_ready_before_accept", 128'(in_ready), 128'd1);
        check_eq("rk_idx_idle", 128'(rk_idx), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (mid) check_eq("sb_after_accept", sb_data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (mid) check_eq("rk_idx_round", 128'(rk_idx), 128'(lat + 1));
            check_eq("in_ready_busy", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
            lat++;
            if (mid && lat == 1)
                check_eq("sb_after_round1", sb_data_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
        end
        check_eq("latency", 128'(lat), 128'd10);
        check_eq("ciphertext", out_data, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("out_valid_after_hs", 128'(out_valid), 128'd0);
        check_eq("in_ready_after_hs", 128'(in_ready), 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key, pt, exp_q[$];
        int           acc_cycle[$];
        int           cyc, w;
        logic         acc, ohs;
        n_checks = 0;
        n_pass   = 0;
        key_sel  = 0;
        load_keys(0, KEY1);
        load_keys(1, KEY3);
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_rk_idx", 128'(rk_idx), 128'd0);
        check_eq("rst_sb_data_out", sb_data_out, 128'd0);
        check_eq("rst_out_data", out_data, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer vectors, with the App.B intermediate values
        check_eq("model_t1", aes_ref(KEY1, PT1), CT1);
        run_block(0, PT1, CT1, 1'b1);
        run_block(1, PT3, CT3, 1'b0);

        // Backpressure: DONE held with out_ready low while a new block waits
        key_sel = 0; in_data = PT1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = PT3;
        w = 0;
        while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
        check_eq("bp_reach_done", 128'(out_valid), 128'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_out_valid", 128'(out_valid), 128'd1);
            check_eq("bp_out_data", out_data, CT1);
            check_eq("bp_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        key_sel = 1;
        check_eq("bp_ready_after_pulse", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_accepted", 128'(in_ready), 128'd0);
        w = 0;
        while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
        check_eq("bp_second_ct", out_data, CT3);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Back-to-back: in_valid and out_ready held high
        key_sel = 0; in_data = PT1; in_valid = 1'b1; out_ready = 1'b1;
        exp_q.push_back(CT1); exp_q.push_back(CT3);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 60) begin
            acc = in_valid && in_ready;
            ohs = out_valid && out_ready;
            if (ohs) begin
                check_eq("b2b_ct", out_data, exp_q.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cycle.push_back(cyc);
                if (acc_cycle.size() == 1) in_data = PT3;
                else in_valid = 1'b0;
            end
            if (ohs) key_sel = 1;
        end
        check_eq("b2b_both_out", 128'(exp_q.size()), 128'd0);
        check_eq("b2b_accepts", 128'(acc_cycle.size()), 128'd2);
        if (acc_cycle.size() == 2)
            check_eq("b2b_spacing", 128'(acc_cycle[1] - acc_cycle[0]), 128'd12);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of round 5
        key_sel = 0; in_data = PT1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_rk_idx5", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
        run_block(0, PT1, CT1, 1'b0);

        // Random keys and plaintexts against the model
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_keys(1, key);
            run_block(1, pt, aes_ref(key, pt), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
